// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//  - state_e      : responder FSM states
//  - LegalBe      : byte-lane patterns accepted for loads and stores
//  - be_legal()   : lane-pattern legality check
//  - word_idx()   : byte address -> 32-bit word index
package mips_mem_pkg;

  localparam int unsigned DefDepthWords = 3072;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StWait,
    StResp
  } state_e;

  // Single bytes, aligned half-words and the full word.
  localparam int unsigned NumLegalBe = 7;
  localparam logic [3:0] LegalBe [NumLegalBe] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NumLegalBe; i++) begin
      if (be == LegalBe[i]) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous data RAM, DepthWords x 32 bits.
// Read-before-write with a registered read port: rdata_o shows the word at addr_i as it was
// before the write performed on the same edge. No reset; contents are only changed by writes.
// Ports:
//  clk_i    clock
//  addr_i   word address (must be < DepthWords)
//  be_i     per-byte write enables, bit i writes byte i
//  wdata_i  write data, lane-aligned
//  rdata_o  registered read data
module dm_ram #(
  parameter int unsigned DepthWords = 3072,
  parameter int unsigned AddrWidth  = $clog2(DepthWords)
) (
  input  logic                 clk_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [DepthWords];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[addr_i];
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data-memory port. Accepts one load/store at a time over a
// valid/ready handshake, applies byte-lane writes and answers after LATENCY cycles. After reset
// it zero-fills the whole RAM before accepting anything.
// Ports:
//  clk        clock, rising edge
//  reset      asynchronous reset, active low
//  req_valid  request present          req_ready  accepting (IDLE only)
//  req_we     1 = store, 0 = load       req_addr   byte address
//  req_be     byte lanes                req_wdata  store data, lane-aligned
//  rsp_valid  response held until rsp_ready
//  rsp_ready  initiator takes response
//  rsp_rdata  load data (0 for stores and errors)
//  rsp_err    request rejected, memory untouched
//  busy       high in CLEAR, WAIT, RESP
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefDepthWords,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_idx_q;
  logic [3:0]       cnt_q;
  logic             we_q;
  logic [29:0]      idx_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;

  logic             accept, last_wait, clr_done, req_err, req_in_range;
  logic [29:0]      req_idx;
  logic [AddrW-1:0] ram_addr;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata, ram_rdata;

  assign req_idx      = word_idx(req_addr);
  assign req_in_range = req_idx < 30'(DEPTH_WORDS);
  assign accept       = (state_q == StIdle) && req_valid;
  assign last_wait    = (state_q == StWait) && (cnt_q == '0);
  assign clr_done     = clr_idx_q == AddrW'(DEPTH_WORDS - 1);
  assign req_err      = !be_legal(be_q) || (idx_q >= 30'(DEPTH_WORDS));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StClear;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (clr_done)  state_d = StIdle;
      StIdle:  if (accept)    state_d = StWait;
      StWait:  if (last_wait) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StClear;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
  end

  // RAM port. In IDLE the RAM reads the presented address every cycle so that, even with
  // LATENCY=1, the word read on the accept edge is ready for the response edge. In WAIT it
  // keeps re-reading the latched word, so the final read reflects every earlier store.
  always_comb begin
    ram_addr  = '0;
    ram_be    = '0;
    ram_wdata = wdata_q;
    unique case (state_q)
      StClear: begin
        ram_addr  = clr_idx_q;
        ram_be    = 4'hF;
        ram_wdata = '0;
      end
      StIdle: begin
        if (req_in_range) ram_addr = req_idx[AddrW-1:0];
      end
      StWait: begin
        if (idx_q < 30'(DEPTH_WORDS)) ram_addr = idx_q[AddrW-1:0];
        if (last_wait && we_q && !req_err) ram_be = be_q;
      end
      default: ;
    endcase
  end

  dm_ram #(
    .DepthWords(DEPTH_WORDS),
    .AddrWidth (AddrW)
  ) u_ram (
    .clk_i  (clk),
    .addr_i (ram_addr),
    .be_i   (ram_be),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // Clear index, latency counter, request latch and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_idx_q   <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state_q == StClear) clr_idx_q <= clr_idx_q + 1'b1;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_idx;
        be_q    <= req_be;
        wdata_q <= req_wdata;
        cnt_q   <= 4'(LATENCY - 1);
      end else if (state_q == StWait) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          rsp_err_q   <= req_err;
          rsp_rdata_q <= (!we_q && !req_err) ? ram_rdata : 32'h0;
        end
      end
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_WORDS=3072, LATENCY=2).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_be   (req_be),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] model [int unsigned];  // only used to print the store trace

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!req_ready && cycles < 5000);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic trace_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = model.exists(addr >> 2) ? model[addr >> 2] : 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    model[addr >> 2] = w;
    $display("%0t@: *%h <= %h", $time, addr, w);
  endtask

  // One full transaction with latency, data and error checks.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    check_eq({tag, "_lat"}, lat, 2);
    check_eq({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check_eq({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    if (we && rsp_valid && !rsp_err) trace_store(addr, be, wdata);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int lat;

    // Reset values
    #2;
    check_eq("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h1);
    repeat (3) @(posedge clk);

    // 1. Zero-fill duration and empty memory
    @(negedge clk); reset = 1'b1;
    wait_ready(cyc);
    check_eq("clear_cycles", cyc, 3072);
    check_eq("idle_busy", {31'h0, busy}, 32'h0);
    txn("ld0", 1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h0, 1'b0);
    txn("ldtop", 1'b0, 32'h0000_2FFC, 4'hF, 32'h0, 32'h0, 1'b0);

    // 2. Full-word store and reload
    txn("st_full", 1'b1, 32'h10, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
    txn("ld_full", 1'b0, 32'h10, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);

    // 3. Byte-lane merges
    txn("st_b1", 1'b1, 32'h10, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0);
    txn("ld_b1", 1'b0, 32'h10, 4'b0001, 32'h0, 32'h1234_AB78, 1'b0);
    txn("st_hi", 1'b1, 32'h10, 4'b1100, 32'hCAFE_0000, 32'h0, 1'b0);
    txn("ld_hi", 1'b0, 32'h10, 4'b1111, 32'h0, 32'hCAFE_AB78, 1'b0);

    // 4. Rejected requests leave memory alone
    txn("st_oor", 1'b1, 32'h3000, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("st_be0110", 1'b1, 32'h10, 4'b0110, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("ld_be0", 1'b0, 32'h10, 4'b0000, 32'h0, 32'h0, 1'b1);
    txn("ld_oor", 1'b0, 32'h3000, 4'b1111, 32'h0, 32'h0, 1'b1);
    txn("ld_after_err", 1'b0, 32'h10, 4'b1111, 32'h0, 32'hCAFE_AB78, 1'b0);

    // 5. Response back-pressure with a second request waiting
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
    @(posedge clk); #1;
    @(negedge clk); req_addr = 32'h2FFC;
    wait_rsp(lat);
    check_eq("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_valid", {31'h0, rsp_valid}, 32'h1);
      check_eq("bp_rdata", rsp_rdata, 32'hCAFE_AB78);
      check_eq("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check_eq("bp_rsp_done", {31'h0, rsp_valid}, 32'h0);
    check_eq("bp_ready_after", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1; req_valid = 1'b0;
    check_eq("bp_second_accepted", {31'h0, req_ready}, 32'h0);
    wait_rsp(lat);
    check_eq("bp2_lat", lat, 2);
    check_eq("bp2_rdata", rsp_rdata, 32'h0);
    check_eq("bp2_err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;

    // 6. Reset during WAIT drops the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; req_valid = 1'b0;
    check_eq("rm_accepted", {31'h0, req_ready}, 32'h0);
    @(negedge clk); reset = 1'b0;
    #1;
    check_eq("rm_busy", {31'h0, busy}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rm_no_rsp", {31'h0, rsp_valid}, 32'h0);
    model.delete();
    @(negedge clk); reset = 1'b1;
    wait_ready(cyc);
    check_eq("rm_clear_cycles", cyc, 3072);
    txn("rm_ld20", 1'b0, 32'h20, 4'hF, 32'h0, 32'h0, 1'b0);
    txn("rm_ld10", 1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
